// File: rtl/display_decoder_if.sv
// Purpose : observed 7-segment scan lines plus the decoded result of display_decoder.
// Latency : n/a (signal bundle only).
// Backpressure: none; the decoder only observes the scan lines, so there is no ready path.
//
// Signals:
//   digit_select    [3:0]  one-hot active-low digit enable (bit0 = ones .. bit3 = thousands)
//   led_select      [6:0]  active-low segments (bit0 = a .. bit6 = g)
//   number          [13:0] last decoded value 0..9999
//   number_valid           one-cycle pulse when number/decode_error update
//   decode_error           last frame contained an unrecognised segment pattern
//   display_stalled        no digit sampled for the stall timeout
// master = display driver side, slave = decoder side.
interface display_decoder_if;
  logic [3:0]  digit_select;
  logic [6:0]  led_select;
  logic [13:0] number;
  logic        number_valid;
  logic        decode_error;
  logic        display_stalled;

  modport master (
    output digit_select, led_select,
    input  number, number_valid, decode_error, display_stalled
  );

  modport slave (
    input  digit_select, led_select,
    output number, number_valid, decode_error, display_stalled
  );
endinterface

// File: rtl/display_decoder.sv
// Purpose : watches a multiplexed active-low 7-segment scan and rebuilds the shown 4-digit value.
// Latency : number_valid rises 1 clock after the sampling edge that completes a 4-digit frame.
// Backpressure: none; pure observer, every completed frame is reported.
//
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   bus    display_decoder_if.slave (scan lines in, number/number_valid/decode_error/display_stalled out)
module display_decoder #(
  parameter int SETTLE_CYCLES = 4,       // 1..255
  parameter int STALL_TIMEOUT = 2**20
) (
  input logic              clk,
  input logic              reset,
  display_decoder_if.slave bus
);

  localparam int         STALL_W     = $clog2(STALL_TIMEOUT + 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  localparam logic [0:0] S_WAIT = 1'b0;
  localparam logic [0:0] S_HELD = 1'b1;

  logic [0:0]         state;
  logic [3:0]         prev_sel;
  logic [7:0]         settle_cnt;
  logic [STALL_W-1:0] stall_cnt;
  logic [3:0]         mask;
  logic [3:0]         err;
  logic [3:0][3:0]    digits;

  logic               sel_legal;
  logic               sel_same;
  logic               sample;
  logic [1:0]         sel_idx;
  logic [3:0]         seg_val;
  logic               seg_bad;
  logic               frame_done;
  logic [3:0]         mask_next;
  logic [3:0]         err_next;
  logic [13:0]        frame_value;

  assign sel_legal  = ($countones(~bus.digit_select) == 1);
  assign sel_same   = (bus.digit_select == prev_sel);
  // The counter has already seen SETTLE_CYCLES-1 stable cycles; this cycle is the last one.
  assign sample     = (state == S_WAIT) && sel_legal && sel_same && (settle_cnt == SETTLE_LAST);
  assign frame_done = (mask == 4'hF);

  always_comb begin
    sel_idx = 2'd0;
    case (bus.digit_select)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_idx = 2'd0;
    endcase
  end

  always_comb begin
    seg_val = 4'd0;
    seg_bad = 1'b0;
    case (bus.led_select)
      7'h40: seg_val = 4'd0;
      7'h79: seg_val = 4'd1;
      7'h24: seg_val = 4'd2;
      7'h30: seg_val = 4'd3;
      7'h19: seg_val = 4'd4;
      7'h12: seg_val = 4'd5;
      7'h02: seg_val = 4'd6;
      7'h78: seg_val = 4'd7;
      7'h00: seg_val = 4'd8;
      7'h10: seg_val = 4'd9;
      7'h7F: seg_val = 4'd0;   // blank digit (leading-zero suppression) reads as 0
      default: seg_bad = 1'b1;
    endcase
  end

  // A completing frame clears mask/error in the same cycle a new sample may land;
  // the new sample is applied on top of the cleared state so it is not lost.
  always_comb begin
    mask_next = frame_done ? 4'h0 : mask;
    err_next  = frame_done ? 4'h0 : err;
    if (sample) begin
      mask_next[sel_idx] = 1'b1;
      err_next[sel_idx]  = seg_bad;
    end
  end

  assign frame_value = 14'(digits[3]) * 14'd1000
                     + 14'(digits[2]) * 14'd100
                     + 14'(digits[1]) * 14'd10
                     + 14'(digits[0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_WAIT;
      prev_sel         <= 4'hF;
      settle_cnt       <= 8'd0;
      stall_cnt        <= '0;
      mask             <= 4'h0;
      err              <= 4'h0;
      digits           <= '0;
      bus.number       <= 14'd0;
      bus.number_valid <= 1'b0;
      bus.decode_error <= 1'b0;
    end else begin
      prev_sel <= bus.digit_select;

      case (state)
        S_WAIT: begin
          if (sample) begin
            state      <= S_HELD;
            settle_cnt <= 8'd0;
          end else if (sel_legal && sel_same) begin
            settle_cnt <= settle_cnt + 8'd1;
          end else begin
            settle_cnt <= 8'd0;
          end
        end
        S_HELD: begin
          // One sample per activation: wait here until the select moves on.
          if (!sel_same) begin
            state      <= S_WAIT;
            settle_cnt <= 8'd0;
          end
        end
        default: begin
          state      <= S_WAIT;
          settle_cnt <= 8'd0;
        end
      endcase

      mask <= mask_next;
      err  <= err_next;
      if (sample) begin
        digits[sel_idx] <= seg_val;
      end

      bus.number_valid <= frame_done;
      if (frame_done) begin
        bus.number       <= frame_value;
        bus.decode_error <= |err;
      end

      if (sample) begin
        stall_cnt <= '0;
      end else if (stall_cnt != STALL_W'(STALL_TIMEOUT)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  assign bus.display_stalled = (stall_cnt == STALL_W'(STALL_TIMEOUT));

endmodule

// File: tb/tb_display_decoder.sv
// Purpose : directed self-checking bench for display_decoder (SETTLE_CYCLES=4, STALL_TIMEOUT=64).
// Latency : checks number_valid exactly one clock after the completing sample edge.
// Backpressure: none on the DUT; the bench drives the scan lines freely.
module tb_display_decoder;

  logic clk;
  logic reset;
  int   errors    = 0;
  int   checks    = 0;
  int   valid_cnt = 0;

  display_decoder_if dd_if();

  display_decoder #(
    .SETTLE_CYCLES(4),
    .STALL_TIMEOUT(64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dd_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count number_valid pulses away from the active edge.
  always @(negedge clk) begin
    if (dd_if.number_valid === 1'b1) valid_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, ending 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show(input int pos, input logic [6:0] seg, input int cyc);
    logic [3:0] s;
    s = 4'b1111;
    s[pos] = 1'b0;
    dd_if.digit_select = s;
    dd_if.led_select   = seg;
    tick(cyc);
  endtask

  // Scan d0..d3; the d3 sample lands on the 5th edge after it is driven,
  // number_valid must follow one edge later and last exactly one cycle.
  task automatic frame(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                       input logic [6:0] s0, input int exp_num, input logic exp_err,
                       input string tag);
    int v0;
    v0 = valid_cnt;
    show(0, s0, 10);
    show(1, s1, 10);
    show(2, s2, 10);
    show(3, s3, 5);
    check({tag, "_valid_before"}, 32'(dd_if.number_valid), 32'd0);
    tick(1);
    check({tag, "_valid_pulse"}, 32'(dd_if.number_valid), 32'd1);
    check({tag, "_number"}, 32'(dd_if.number), 32'(exp_num));
    check({tag, "_decode_error"}, 32'(dd_if.decode_error), 32'(exp_err));
    tick(1);
    check({tag, "_valid_drop"}, 32'(dd_if.number_valid), 32'd0);
    check({tag, "_pulse_count"}, 32'(valid_cnt), 32'(v0 + 1));
    tick(3);
  endtask

  initial begin
    int v0;
    reset = 1'b0;
    dd_if.digit_select = 4'hF;
    dd_if.led_select   = 7'h7F;

    // Reset held with active scanning: nothing may come out.
    tick(2);
    show(0, 7'h19, 10);
    show(1, 7'h30, 10);
    show(2, 7'h24, 10);
    show(3, 7'h79, 10);
    check("rst_number", 32'(dd_if.number), 32'd0);
    check("rst_valid", 32'(dd_if.number_valid), 32'd0);
    check("rst_decode_error", 32'(dd_if.decode_error), 32'd0);
    check("rst_stalled", 32'(dd_if.display_stalled), 32'd0);
    check("rst_pulses", 32'(valid_cnt), 32'd0);

    reset = 1'b1;
    tick(2);

    frame(7'h79, 7'h24, 7'h30, 7'h19, 1234, 1'b0, "f1234_a");
    frame(7'h79, 7'h24, 7'h30, 7'h19, 1234, 1'b0, "f1234_b");
    frame(7'h7F, 7'h7F, 7'h79, 7'h02, 16,   1'b0, "blank16");
    frame(7'h10, 7'h55, 7'h10, 7'h10, 9099, 1'b1, "bad9099");
    frame(7'h10, 7'h10, 7'h10, 7'h10, 9999, 1'b0, "clean9999");

    // Sample d0, then glitchy/illegal selects, then freeze idle: the stall
    // counter runs from the d0 sample regardless of the glitches.
    v0 = valid_cnt;
    show(0, 7'h19, 5);
    dd_if.digit_select = 4'b1101;
    dd_if.led_select   = 7'h30;
    tick(3);
    dd_if.digit_select = 4'b0000;
    tick(5);
    dd_if.digit_select = 4'b1100;
    tick(5);
    dd_if.digit_select = 4'b1111;
    tick(50);
    check("glitch_no_frame", 32'(valid_cnt), 32'(v0));
    check("stall_at_63", 32'(dd_if.display_stalled), 32'd0);
    tick(1);
    check("stall_at_64", 32'(dd_if.display_stalled), 32'd1);
    tick(10);
    check("stall_saturated", 32'(dd_if.display_stalled), 32'd1);
    show(1, 7'h30, 4);
    check("stall_before_sample", 32'(dd_if.display_stalled), 32'd1);
    tick(1);
    check("stall_cleared", 32'(dd_if.display_stalled), 32'd0);
    tick(5);
    // d0 from before the stall is still in the mask.
    show(2, 7'h24, 10);
    show(3, 7'h79, 5);
    tick(1);
    check("stall_keep_mask_valid", 32'(dd_if.number_valid), 32'd1);
    check("stall_keep_mask_number", 32'(dd_if.number), 32'd1234);
    tick(3);

    // Mid-frame reset discards the partial frame.
    show(0, 7'h02, 10);
    show(1, 7'h02, 10);
    reset = 1'b0;
    #1;
    check("midrst_async_number", 32'(dd_if.number), 32'd0);
    tick(3);
    reset = 1'b1;
    tick(1);
    v0 = valid_cnt;
    show(3, 7'h78, 10);
    show(2, 7'h00, 10);
    show(1, 7'h12, 10);
    check("midrst_no_partial", 32'(valid_cnt), 32'(v0));
    check("midrst_number_held", 32'(dd_if.number), 32'd0);
    show(0, 7'h40, 5);
    tick(1);
    check("midrst_valid", 32'(dd_if.number_valid), 32'd1);
    check("midrst_number", 32'(dd_if.number), 32'd7850);
    check("midrst_decode_error", 32'(dd_if.decode_error), 32'd0);
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
